// File: rtl/loopback_copy_engine.sv
// Indexed copy engine: streams cfg_len lines from a source buffer to a destination buffer,
// with credit-limited reads into a local FIFO and registered request outputs.
module loopback_copy_engine #(
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned IDX_W      = 11,
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W:0]    cfg_len,
    input  logic [IDX_W-1:0]  cfg_src_base,
    input  logic [IDX_W-1:0]  cfg_dst_base,
    input  logic              cfg_src_desc,
    input  logic              cfg_dst_desc,
    output logic              rd_req_valid,
    output logic [IDX_W-1:0]  rd_req_index,
    input  logic              rd_req_full,
    input  logic              rd_rsp_valid,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_req_valid,
    output logic [IDX_W-1:0]  wr_req_index,
    output logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_req_full,
    output logic              busy,
    output logic              done,
    output logic              err_rsp
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_next;
    logic              src_desc, dst_desc;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic [LW-1:0]     rd_left, wr_left;
    logic [CW-1:0]     credit, outstanding, count;
    logic [AW-1:0]     push_ptr, pop_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic start_run, issue, pop, push, bad_rsp;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state and per-cycle read/write decisions
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        issue      = 1'b0;
        pop        = 1'b0;
        push       = rd_rsp_valid && (outstanding != '0);
        bad_rsp    = rd_rsp_valid && (outstanding == '0);
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = (cfg_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                issue = (rd_left != '0) && !rd_req_full && (credit != '0);
                pop   = (count != '0) && !wr_req_full;
                if (wr_req_valid && (wr_left == '0)) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_desc     <= 1'b0;
            dst_desc     <= 1'b0;
            rd_idx       <= '0;
            wr_idx       <= '0;
            rd_left      <= '0;
            wr_left      <= '0;
            credit       <= CW'(FIFO_DEPTH);
            outstanding  <= '0;
            count        <= '0;
            push_ptr     <= '0;
            pop_ptr      <= '0;
            rd_req_valid <= 1'b0;
            rd_req_index <= '0;
            wr_req_valid <= 1'b0;
            wr_req_index <= '0;
            wr_req_data  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_rsp      <= 1'b0;
        end else begin
            rd_req_valid <= issue;
            wr_req_valid <= pop;
            busy         <= (state_next == S_RUN);
            done         <= (state == S_DONE);
            credit       <= credit - CW'(issue) + CW'(pop);
            outstanding  <= outstanding + CW'(issue) - CW'(push);
            count        <= count + CW'(push) - CW'(pop);
            if (push) push_ptr <= push_ptr + AW'(1);
            if (start_run) begin
                src_desc <= cfg_src_desc;
                dst_desc <= cfg_dst_desc;
                rd_idx   <= cfg_src_base;
                wr_idx   <= cfg_dst_base;
                rd_left  <= cfg_len;
                wr_left  <= cfg_len;
            end
            if (issue) begin
                rd_req_index <= rd_idx;
                rd_idx       <= src_desc ? rd_idx - IDX_W'(1) : rd_idx + IDX_W'(1);
                rd_left      <= rd_left - LW'(1);
            end
            if (pop) begin
                wr_req_index <= wr_idx;
                wr_req_data  <= mem[pop_ptr];
                wr_idx       <= dst_desc ? wr_idx - IDX_W'(1) : wr_idx + IDX_W'(1);
                wr_left      <= wr_left - LW'(1);
                pop_ptr      <= pop_ptr + AW'(1);
            end
            // A stray response in the start cycle still flags
            if (start_run) err_rsp <= 1'b0;
            if (bad_rsp)   err_rsp <= 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[push_ptr] <= rd_rsp_data;
    end

    // Credits keep occupancy plus in-flight reads within depth
    push_never_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_loopback_copy_engine.sv
// Randomized scoreboard bench for loopback_copy_engine: an index-arithmetic model queues
// expected reads/writes, a responder serves reads and monitors pop and compare.
module tb_loopback_copy_engine;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = 11;
    localparam int unsigned LW     = IDX_W + 1;
    localparam int unsigned DEPTH  = 4;
    localparam int          NIDX   = 2048;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [IDX_W:0]    cfg_len = '0;
    logic [IDX_W-1:0]  cfg_src_base = '0, cfg_dst_base = '0;
    logic              cfg_src_desc = 1'b0, cfg_dst_desc = 1'b0;
    logic              rd_req_valid, wr_req_valid, busy, done, err_rsp;
    logic [IDX_W-1:0]  rd_req_index, wr_req_index;
    logic [DATA_W-1:0] wr_req_data;
    logic              rd_req_full = 1'b0, wr_req_full = 1'b0;
    logic              rd_rsp_valid = 1'b0;
    logic [DATA_W-1:0] rd_rsp_data = '0;

    loopback_copy_engine #(.DATA_W(DATA_W), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .cfg_src_desc(cfg_src_desc), .cfg_dst_desc(cfg_dst_desc),
        .rd_req_valid(rd_req_valid), .rd_req_index(rd_req_index), .rd_req_full(rd_req_full),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_index(wr_req_index), .wr_req_data(wr_req_data),
        .wr_req_full(wr_req_full), .busy(busy), .done(done), .err_rsp(err_rsp)
    );

    initial forever #5 clk = ~clk;

    logic [DATA_W-1:0] src_mem [NIDX];
    wr_exp_t           exp_wr_q[$];
    logic [IDX_W-1:0]  exp_rd_q[$];
    logic [IDX_W-1:0]  pend[$];

    int checks = 0, failures = 0;
    int done_total = 0, busy_cycles = 0, writes_seen = 0, rd_issue_cnt = 0;
    int stale_req = 0, stale_sent = 0;
    bit zero_lat = 1'b1, wr_full_rand = 1'b0, wr_full_hold = 1'b0, rd_full_rand = 1'b0;
    bit last_wr_full = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic fill_src();
        for (int i = 0; i < NIDX; i++) src_mem[i] = {$urandom, $urandom};
    endtask

    // Reference: line n reads src_base +/- n and writes dst_base +/- n, modulo 2^IDX_W
    task automatic push_expect(input int len, input int sb, input int db, input bit sd, input bit dd);
        for (int n = 0; n < len; n++) begin
            int ri;
            int wi;
            wr_exp_t e;
            ri = sd ? sb - n : sb + n;
            wi = dd ? db - n : db + n;
            ri = ((ri % NIDX) + NIDX) % NIDX;
            wi = ((wi % NIDX) + NIDX) % NIDX;
            exp_rd_q.push_back(IDX_W'(ri));
            e.idx  = IDX_W'(wi);
            e.data = src_mem[ri];
            exp_wr_q.push_back(e);
        end
    endtask

    task automatic start_pulse(input int len, input int sb, input int db, input bit sd,
                               input bit dd, input bit expect_run);
        @(posedge clk); #1;
        cfg_len      = LW'(len);
        cfg_src_base = IDX_W'(sb);
        cfg_dst_base = IDX_W'(db);
        cfg_src_desc = sd;
        cfg_dst_desc = dd;
        start        = 1'b1;
        if (expect_run) push_expect(len, sb, db, sd, dd);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int snap, input int budget);
        int k;
        k = 0;
        while (done_total == snap && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", 64'(done_total != snap), 64'(1));
    endtask

    task automatic finish_run(input int snap);
        repeat (3) @(negedge clk);
        check("done_once", 64'(done_total - snap), 64'(1));
        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
        check("rd_queue_drained", 64'(exp_rd_q.size()), 64'(0));
        check("err_rsp_clear", 64'(err_rsp), 64'(0));
    endtask

    task automatic run_copy(input int len, input int sb, input int db, input bit sd, input bit dd);
        int snap;
        fill_src();
        snap = done_total;
        start_pulse(len, sb, db, sd, dd, 1'b1);
        wait_done(snap, len * 40 + 100);
        finish_run(snap);
    endtask

    // Backpressure driver
    initial forever begin
        @(posedge clk); #1;
        wr_req_full = wr_full_hold || (wr_full_rand && ($urandom_range(0, 2) == 0));
        rd_req_full = rd_full_rand && ($urandom_range(0, 3) == 0);
    end

    // Read responder: checks request order, answers in order (same cycle or delayed)
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pend.delete();
            rd_rsp_valid = 1'b0;
        end else begin
            if (rd_req_valid) begin
                rd_issue_cnt++;
                if (exp_rd_q.size() == 0) check("unexpected_read", 64'(rd_req_index), 64'(0) - 64'(1));
                else check("rd_index", 64'(rd_req_index), 64'(exp_rd_q.pop_front()));
                pend.push_back(rd_req_index);
            end
            if (stale_sent < stale_req) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = {DATA_W{1'b1}};
                stale_sent++;
            end else if (pend.size() > 0 && (zero_lat || $urandom_range(0, 2) == 0)) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = src_mem[pend.pop_front()];
            end else begin
                rd_rsp_valid = 1'b0;
            end
        end
    end

    // Output monitor: write scoreboard, done/busy bookkeeping
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (wr_req_valid) begin
                writes_seen++;
                check("wr_after_full", 64'(last_wr_full), 64'(0));
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 64'(wr_req_index), 64'(0) - 64'(1));
                end else begin
                    wr_exp_t e;
                    e = exp_wr_q.pop_front();
                    check("wr_index", 64'(wr_req_index), 64'(e.idx));
                    check("wr_data", wr_req_data, e.data);
                end
            end
            if (done) begin
                done_total++;
                check("done_not_busy", 64'(busy), 64'(0));
            end
            if (busy) busy_cycles++;
        end
        last_wr_full = wr_req_full;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, bsnap, rsnap, wsnap, k;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", {59'(0), rd_req_valid, wr_req_valid, busy, done, err_rsp}, 64'(0));

        // Basic ascending copy, zero-latency responder
        fill_src();
        snap  = done_total;
        bsnap = busy_cycles;
        start_pulse(8, 0, 100, 1'b0, 1'b0, 1'b1);
        wait_done(snap, 200);
        check("busy_at_least_9", 64'((busy_cycles - bsnap) >= 9), 64'(1));
        finish_run(snap);

        // Descending source, destination wraps past the top index
        run_copy(4, 3, 2046, 1'b1, 1'b0);

        // Credit stall: writes blocked, only DEPTH reads may be issued
        fill_src();
        wr_full_hold = 1'b1;
        snap  = done_total;
        rsnap = rd_issue_cnt;
        start_pulse(16, 40, 900, 1'b0, 1'b1, 1'b1);
        repeat (50) @(negedge clk);
        check("credit_stall_reads", 64'(rd_issue_cnt - rsnap), 64'(DEPTH));
        wr_full_hold = 1'b0;
        wait_done(snap, 400);
        finish_run(snap);

        // Zero-length run: no traffic, done two cycles after start
        snap = done_total;
        start_pulse(0, 7, 7, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("len0_done_early", 64'(done), 64'(0));
        @(negedge clk);
        check("len0_done_pulse", 64'(done), 64'(1));
        @(negedge clk);
        check("len0_done_single", 64'(done), 64'(0));
        check("len0_no_busy", 64'(busy), 64'(0));

        // Reset mid-run abandons the run; stale responses flag err_rsp
        zero_lat = 1'b0;
        fill_src();
        snap  = done_total;
        wsnap = writes_seen;
        start_pulse(10, 500, 600, 1'b0, 1'b1, 1'b1);
        k = 0;
        while (writes_seen - wsnap < 5 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("reached_line5", 64'(writes_seen - wsnap >= 5), 64'(1));
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("reset_midrun_outputs", {61'(0), rd_req_valid, wr_req_valid, busy}, 64'(0));
        exp_wr_q.delete();
        exp_rd_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        stale_req = stale_req + 2;
        k = 0;
        while (stale_sent < stale_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        @(negedge clk);
        check("stale_sets_err", 64'(err_rsp), 64'(1));
        check("no_done_after_abort", 64'(done_total - snap), 64'(0));
        fill_src();
        snap = done_total;
        start_pulse(3, 1200, 1300, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("start_clears_err", 64'(err_rsp), 64'(0));
        wait_done(snap, 200);
        finish_run(snap);

        // Start and cfg changes while busy are ignored
        fill_src();
        snap = done_total;
        start_pulse(12, 77, 1500, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        start_pulse(5, 1000, 10, 1'b1, 1'b1, 1'b0);
        wait_done(snap, 600);
        finish_run(snap);

        // Randomized runs with backpressure and variable latency
        wr_full_rand = 1'b1;
        rd_full_rand = 1'b1;
        run_copy(20, 2040, 5, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            zero_lat = 1'($urandom_range(0, 1));
            run_copy(int'($urandom_range(1, 40)), int'($urandom_range(0, NIDX - 1)),
                     int'($urandom_range(0, NIDX - 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
